// File: rtl/dds_waveform_gen.sv
// ============================================================================
// Module   : dds_waveform_gen
// Purpose  : Direct digital synthesis stage. A phase accumulator, an
//            arithmetic waveform shaper and an amplitude scaler form a
//            three-stage pipeline that produces the sample stream read back
//            by the UART transmit path. New parameter sets from the UART
//            command block are held in a shadow comparison and committed only
//            at a phase wrap, or at once while the accumulator is stopped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_waveform_gen #(
    parameter int ACC_W    = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       signalNumber,
    input  logic [ACC_W-1:0] adder,
    input  logic [31:0]      amplitude,
    output logic [31:0]      signal,
    output logic             cycleStart,
    output logic             paramsPending
);

    // ------------------------------------------------------------------------
    // Waveform selector codes and gain limits
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_SEL_OFF     = 8'd0;
    localparam logic [7:0] c_SEL_SQUARE  = 8'd1;
    localparam logic [7:0] c_SEL_SAW     = 8'd2;
    localparam logic [7:0] c_SEL_TRI     = 8'd3;
    localparam logic [7:0] c_SEL_REVSAW  = 8'd4;
    localparam logic [7:0] c_SEL_DC      = 8'd5;

    // Unity gain is 1.0 in a fixed-point format with SAMPLE_W fraction bits.
    localparam logic [31:0]         c_UNITY      = 32'd1 << SAMPLE_W;
    localparam logic [SAMPLE_W:0]   c_UNITY_GAIN = c_UNITY[SAMPLE_W:0];
    localparam logic [SAMPLE_W-1:0] c_WAVE_MAX   = {SAMPLE_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] c_WAVE_ZERO  = {SAMPLE_W{1'b0}};

    // ------------------------------------------------------------------------
    // Stage 0 state: phase accumulator and the active parameter set.
    // The active set is registered on the same edge as the phase, so the
    // selector and gain visible next to a phase value are exactly the ones
    // that belong to that sample.
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] r_phase;
    logic [7:0]       r_act_sel;
    logic [ACC_W-1:0] r_act_add;
    logic [31:0]      r_act_amp;
    logic             r_pending;
    logic             r_phase_start;

    // Stage 1: shaped waveform plus the gain that travels with it
    logic [SAMPLE_W-1:0] r_wave;
    logic [SAMPLE_W:0]   r_s1_gain;
    logic                r_s1_start;

    // Stage 2: scaled output sample
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_s2_start;

    // ------------------------------------------------------------------------
    // Stage 0 combinational terms
    // ------------------------------------------------------------------------
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_phase_next;
    logic             w_wrap;
    logic             w_differ;
    logic             w_add_zero;
    logic             w_commit;
    logic             w_start_next;

    // The carry out of the accumulator add marks the start of a new period.
    assign w_sum        = {1'b0, r_phase} + {1'b0, r_act_add};
    assign w_wrap       = w_sum[ACC_W];
    assign w_phase_next = w_sum[ACC_W-1:0];

    // Any difference between the command registers and the active set is a
    // pending change.
    assign w_differ   = ({signalNumber, adder, amplitude} !=
                         {r_act_sel, r_act_add, r_act_amp});
    assign w_add_zero = (r_act_add == '0);

    // Commit only on a period boundary so a waveform is never cut mid-cycle;
    // a stopped accumulator never wraps, so it commits immediately instead.
    assign w_commit = r_pending && (w_wrap || w_add_zero);

    // A commit out of the stopped state starts a fresh period as well.
    assign w_start_next = w_wrap || (w_commit && w_add_zero);

    // Phase accumulator, active parameter set and pending flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase       <= '0;
            r_act_sel     <= '0;
            r_act_add     <= '0;
            r_act_amp     <= '0;
            r_pending     <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            // The phase always advances with the outgoing increment; a commit
            // only affects the adds that follow it.
            r_phase       <= w_phase_next;
            r_phase_start <= w_start_next;
            if (w_commit) begin
                r_act_sel <= signalNumber;
                r_act_add <= adder;
                r_act_amp <= amplitude;
            end
            // After a commit the active set equals this cycle's inputs, so a
            // difference seen on the next cycle means a fresh change.
            r_pending <= w_commit ? 1'b0 : w_differ;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 combinational terms: waveform shaping and gain clamp
    // ------------------------------------------------------------------------
    logic [SAMPLE_W-1:0] w_p;
    logic [SAMPLE_W-1:0] w_t;
    logic                w_half;
    logic [SAMPLE_W-1:0] w_wave;
    logic [SAMPLE_W:0]   w_gain;

    // p is the coarse phase; t is the same window shifted up one bit, which
    // runs twice as fast and folds into the triangle.
    assign w_p    = r_phase[ACC_W-1 -: SAMPLE_W];
    assign w_t    = r_phase[ACC_W-2 -: SAMPLE_W];
    assign w_half = r_phase[ACC_W-1];

    // Waveform shaper selected by the active waveform code
    always_comb begin
        w_wave = c_WAVE_ZERO;
        case (r_act_sel)
            c_SEL_OFF:    w_wave = c_WAVE_ZERO;
            c_SEL_SQUARE: w_wave = w_half ? c_WAVE_ZERO : c_WAVE_MAX;
            c_SEL_SAW:    w_wave = w_p;
            c_SEL_TRI:    w_wave = w_half ? ~w_t : w_t;
            c_SEL_REVSAW: w_wave = ~w_p;
            c_SEL_DC:     w_wave = c_WAVE_MAX;
            default:      w_wave = c_WAVE_ZERO;
        endcase
    end

    // Gains above unity saturate so the scaled sample never overflows.
    assign w_gain = (r_act_amp > c_UNITY) ? c_UNITY_GAIN
                                          : r_act_amp[SAMPLE_W:0];

    // Stage 1 register: shaped sample with its gain and period marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wave     <= '0;
            r_s1_gain  <= '0;
            r_s1_start <= 1'b0;
        end else begin
            r_wave     <= w_wave;
            r_s1_gain  <= w_gain;
            r_s1_start <= r_phase_start;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: amplitude scaling
    // ------------------------------------------------------------------------
    logic [SAMPLE_W-1:0] w_scaled;

    // wave * gain keeps the integer part of the fixed-point product; with the
    // gain clamped to unity the result always fits in SAMPLE_W bits.
    assign w_scaled = SAMPLE_W'(({{(SAMPLE_W + 1){1'b0}}, r_wave} *
                                 {{SAMPLE_W{1'b0}}, r_s1_gain}) >> SAMPLE_W);

    // Stage 2 register: scaled output sample and its period marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample   <= '0;
            r_s2_start <= 1'b0;
        end else begin
            r_sample   <= w_scaled;
            r_s2_start <= r_s1_start;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign signal        = {{(32 - SAMPLE_W){1'b0}}, r_sample};
    assign cycleStart    = r_s2_start;
    assign paramsPending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_dds_waveform_gen.sv
// ============================================================================
// Module   : tb_dds_waveform_gen
// Purpose  : Self-checking bench for dds_waveform_gen: directed waveform
//            scenarios against fixed sample tables, then randomized parameter
//            sequences against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_waveform_gen;

    logic        clk;
    logic        reset;
    logic [7:0]  signalNumber;
    logic [31:0] adder;
    logic [31:0] amplitude;
    logic [31:0] signal;
    logic        cycleStart;
    logic        paramsPending;

    int checks   = 0;
    int failures = 0;

    dds_waveform_gen dut (
        .clk           (clk),
        .reset         (reset),
        .signalNumber  (signalNumber),
        .adder         (adder),
        .amplitude     (amplitude),
        .signal        (signal),
        .cycleStart    (cycleStart),
        .paramsPending (paramsPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: phase and parameters as plain integers, output delayed
    // by two samples through a one-entry hold plus the output value.
    // ------------------------------------------------------------------------
    longint unsigned m_phase, m_add, m_amp;
    int unsigned     m_sel;
    bit              m_pend, m_start;
    int unsigned     d1_val, m_sig;
    bit              d1_start, m_cs;

    function automatic int unsigned model_sample(int unsigned sel,
                                                 longint unsigned ph,
                                                 longint unsigned amp);
        longint unsigned w, g, t;
        bit half;
        half = (ph >= 64'h8000_0000);
        case (sel)
            1: w = half ? 0 : 65535;
            2: w = ph / 65536;
            3: begin
                t = (ph % 64'h8000_0000) / 32768;
                w = half ? 65535 - t : t;
            end
            4: w = 65535 - ph / 65536;
            5: w = 65535;
            default: w = 0;
        endcase
        g = (amp > 65536) ? 65536 : amp;
        return int'((w * g) / 65536);
    endfunction

    always @(posedge clk) begin
        longint unsigned sum;
        bit wrap, differ, commit;
        if (reset) begin
            m_phase = 0; m_add = 0; m_amp = 0; m_sel = 0;
            m_pend = 0; m_start = 0;
            d1_val = 0; d1_start = 0; m_sig = 0; m_cs = 0;
        end else begin
            m_sig    = d1_val;
            m_cs     = d1_start;
            d1_val   = model_sample(m_sel, m_phase, m_amp);
            d1_start = m_start;
            sum      = m_phase + m_add;
            wrap     = (sum >= 64'h1_0000_0000);
            differ   = (int'(signalNumber) != m_sel) || (64'(adder) != m_add) ||
                       (64'(amplitude) != m_amp);
            commit   = m_pend && (wrap || m_add == 0);
            m_start  = wrap || (commit && m_add == 0);
            m_phase  = sum % 64'h1_0000_0000;
            if (commit) begin
                m_sel = signalNumber;
                m_add = adder;
                m_amp = amplitude;
            end
            m_pend = commit ? 1'b0 : differ;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------------
    task automatic apply_reset(input logic [7:0] sel, input logic [31:0] add,
                               input logic [31:0] amp);
        @(negedge clk);
        reset        = 1'b1;
        signalNumber = sel;
        adder        = add;
        amplitude    = amp;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (from a negedge) for a cycleStart sample, bounded.
    task automatic wait_start(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            if (cycleStart === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; signalNumber = 8'd0; adder = 32'd0; amplitude = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (signal !== 32'd0) begin
            failures++; $display("FAIL reset_signal: got %h expected %h", signal, 32'd0);
        end
        checks++;
        if (cycleStart !== 1'b0) begin
            failures++; $display("FAIL reset_cycleStart: got %b expected 0", cycleStart);
        end
        checks++;
        if (paramsPending !== 1'b0) begin
            failures++; $display("FAIL reset_pending: got %b expected 0", paramsPending);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (paramsPending !== 1'b0 || signal !== 32'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got pend=%b sig=%h expected pend=0 sig=0",
                     paramsPending, signal);
        end
    endtask

    task automatic test_sawtooth();
        logic [31:0] exp_tab [4] = '{32'h0000, 32'h4000, 32'h8000, 32'hC000};
        bit ok; int waited;
        apply_reset(8'd2, 32'h4000_0000, 32'h0001_0000);
        wait_start(ok, waited);
        checks++;
        if (!ok || waited != 4) begin
            failures++;
            $display("FAIL saw_first_start: got ok=%0d wait=%0d expected ok=1 wait=4", ok, waited);
            return;
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (signal !== exp_tab[k % 4] || cycleStart !== (k % 4 == 0)) begin
                failures++;
                $display("FAIL saw_sample%0d: got %h/%b expected %h/%b", k, signal,
                         cycleStart, exp_tab[k % 4], (k % 4 == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gain();
        logic [31:0] amps [2] = '{32'h0000_8000, 32'h0002_0000};
        logic [31:0] half_tab [4] = '{32'h0000, 32'h2000, 32'h4000, 32'h6000};
        logic [31:0] full_tab [4] = '{32'h0000, 32'h4000, 32'h8000, 32'hC000};
        bit ok; int waited;
        logic [31:0] e;
        for (int c = 0; c < 2; c++) begin
            apply_reset(8'd2, 32'h4000_0000, amps[c]);
            wait_start(ok, waited);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL gain%0d_start: got timeout expected cycleStart", c);
                continue;
            end
            for (int k = 0; k < 8; k++) begin
                e = (c == 0) ? half_tab[k % 4] : full_tab[k % 4];
                checks++;
                if (signal !== e) begin
                    failures++;
                    $display("FAIL gain%0d_sample%0d: got %h expected %h", c, k, signal, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_triangle();
        logic [31:0] exp_tab [8] = '{32'h0000, 32'h4000, 32'h8000, 32'hC000,
                                     32'hFFFF, 32'hBFFF, 32'h7FFF, 32'h3FFF};
        bit ok; int waited;
        apply_reset(8'd3, 32'h2000_0000, 32'h0001_0000);
        wait_start(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL tri_start: got timeout expected cycleStart");
            return;
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (signal !== exp_tab[k % 8] || cycleStart !== (k % 8 == 0)) begin
                failures++;
                $display("FAIL tri_sample%0d: got %h/%b expected %h/%b", k, signal,
                         cycleStart, exp_tab[k % 8], (k % 8 == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_retune();
        logic [31:0] sig_tab [7] = '{32'h4000, 32'h8000, 32'hC000, 32'h0000,
                                     32'h8000, 32'h0000, 32'h8000};
        bit cs_tab [7]   = '{0, 0, 0, 1, 0, 1, 0};
        bit pend_tab [7] = '{1, 0, 0, 0, 0, 0, 0};
        bit ok; int waited;
        apply_reset(8'd2, 32'h4000_0000, 32'h0001_0000);
        wait_start(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL retune_start: got timeout expected cycleStart");
            return;
        end
        adder = 32'h8000_0000;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (signal !== sig_tab[k] || cycleStart !== cs_tab[k] ||
                paramsPending !== pend_tab[k]) begin
                failures++;
                $display("FAIL retune_step%0d: got %h/%b/%b expected %h/%b/%b", k, signal,
                         cycleStart, paramsPending, sig_tab[k], cs_tab[k], pend_tab[k]);
            end
        end
    endtask

    task automatic test_square_off();
        logic [31:0] sig_tab [6] = '{32'h0000, 32'hFFFF, 32'h0000, 32'h0000,
                                     32'h0000, 32'h0000};
        bit cs_tab [6] = '{0, 1, 0, 1, 0, 1};
        bit ok; int waited;
        apply_reset(8'd1, 32'h8000_0000, 32'h0001_0000);
        wait_start(ok, waited);
        checks++;
        if (!ok || signal !== 32'hFFFF) begin
            failures++;
            $display("FAIL square_first: got ok=%0d sig=%h expected ok=1 sig=ffff", ok, signal);
            return;
        end
        @(negedge clk);
        checks++;
        if (signal !== 32'h0000) begin
            failures++; $display("FAIL square_low: got %h expected %h", signal, 32'h0);
        end
        @(negedge clk);
        signalNumber = 8'd9;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (signal !== sig_tab[k] || cycleStart !== cs_tab[k]) begin
                failures++;
                $display("FAIL off_step%0d: got %h/%b expected %h/%b", k, signal,
                         cycleStart, sig_tab[k], cs_tab[k]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset(8'd5, 32'h1000_0000, 32'h0001_0000);
        repeat (10) @(negedge clk);
        checks++;
        if (signal !== 32'hFFFF) begin
            failures++; $display("FAIL dc_running: got %h expected %h", signal, 32'hFFFF);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (signal !== 32'd0 || cycleStart !== 1'b0 || paramsPending !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: got %h/%b/%b expected 0/0/0", signal,
                     cycleStart, paramsPending);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (signal !== ((i == 4) ? 32'hFFFF : 32'h0) || cycleStart !== (i == 4) ||
                paramsPending !== (i == 1)) begin
                failures++;
                $display("FAIL resume_step%0d: got %h/%b/%b expected %h/%b/%b", i, signal,
                         cycleStart, paramsPending, (i == 4) ? 32'hFFFF : 32'h0,
                         (i == 4), (i == 1));
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 9) == 0) reset = 1'b1;
            signalNumber = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                       : 8'($urandom_range(0, 6));
            case ($urandom_range(0, 3))
                0: adder = $urandom;
                1: adder = {4'($urandom_range(1, 15)), 28'h0};
                2: adder = 32'd0;
                default: adder = {8'($urandom_range(1, 255)), 24'($urandom)};
            endcase
            case ($urandom_range(0, 2))
                0: amplitude = 32'h0001_0000;
                1: amplitude = 32'($urandom_range(0, 32'h1_FFFF));
                default: amplitude = $urandom;
            endcase
            hold = $urandom_range(3, 40);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                reset = 1'b0;
                checks++;
                if (signal !== m_sig || cycleStart !== m_cs || paramsPending !== m_pend) begin
                    failures++;
                    $display("FAIL random_seg%0d_cyc%0d: got %h/%b/%b expected %h/%b/%b",
                             seg, c, signal, cycleStart, paramsPending, m_sig, m_cs, m_pend);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; signalNumber = 8'd0; adder = 32'd0; amplitude = 32'd0;
        test_reset();
        test_sawtooth();
        test_gain();
        test_triangle();
        test_retune();
        test_square_off();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
